freq_meter: RTL and testbench

- Measures the frequency of an external square-wave input against clk_100M over a fixed gate window.
- Counts rising edges of sig_in per window and reports the result in binary and in packed BCD for the 7-segment display path.
- Sits at the receiving end of the divided-clock outputs (clk_100 … clk_1) and of external signal inputs; used to verify divider outputs on the board.

---
 rtl/freq_meter.sv | 178 +++++++++++++++++
 tb/tb_freq_meter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of sig_in over a fixed gate window of
// clk_100M cycles and reports the count in binary and packed BCD.
//
// Conversion FSM states:
//   state  | meaning
//   S_IDLE | waiting for the end of a gate window
//   S_CONV | double-dabble running, one shift-and-add-3 step per cycle
//   S_DONE | freq_bcd just updated, valid high for this cycle only
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 24,
    parameter int DIGITS      = 8
) (
    input  logic                  clk_100M,
    input  logic                  rst,
    input  logic                  sig_in,
    output logic [CNT_W-1:0]      freq_bin,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  ovf,
    output logic                  busy,
    output logic                  valid
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int SW = $clog2(CNT_W + 1);
    localparam int BW = 4 * DIGITS;

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(CNT_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Synchroniser and edge-detect stages
    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Gate window and edge counting
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] freq_bin_q, freq_bin_d;
    logic             ovf_q, ovf_d;

    // BCD conversion
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] sh_q, sh_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [SW-1:0]    step_q, step_d;
    logic [BW-1:0]    freq_bcd_q, freq_bcd_d;

    logic             edge_det;
    logic             gate_end;
    logic [CNT_W-1:0] cnt_inc;
    logic             sticky_inc;
    logic [BW-1:0]    adj;
    logic [BW+CNT_W-1:0] shifted;

    assign edge_det = sync_q & ~dly_q;
    assign gate_end = (gate_q == GATE_LAST);

    // Two-flop synchroniser followed by one delay stage for edge detection
    always_comb begin
        meta_d = sig_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Free-running gate counter and saturating edge counter; an edge seen in
    // the gate-end cycle still belongs to the closing window
    always_comb begin
        gate_d = gate_end ? '0 : gate_q + GW'(1);

        cnt_inc    = cnt_q;
        sticky_inc = sticky_q;
        if (edge_det) begin
            if (&cnt_q) begin
                sticky_inc = 1'b1;
            end else begin
                cnt_inc = cnt_q + CNT_W'(1);
            end
        end

        cnt_d      = gate_end ? '0   : cnt_inc;
        sticky_d   = gate_end ? 1'b0 : sticky_inc;
        freq_bin_d = gate_end ? cnt_inc    : freq_bin_q;
        ovf_d      = gate_end ? sticky_inc : ovf_q;
    end

    // Double-dabble step: add 3 to every digit >= 5, then shift the whole
    // {bcd, binary} pair left by one
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj, sh_q} << 1;
    end

    // Conversion FSM; the window length guarantees no gate end lands in CONV
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        step_d     = step_q;
        freq_bcd_d = freq_bcd_q;
        case (state_q)
            S_IDLE: begin
                if (gate_end) begin
                    state_d = S_CONV;
                    sh_d    = cnt_inc;
                    acc_d   = '0;
                    step_d  = STEP_LAST;
                end
            end
            S_CONV: begin
                acc_d  = shifted[BW+CNT_W-1:CNT_W];
                sh_d   = shifted[CNT_W-1:0];
                step_d = step_q - SW'(1);
                if (step_q == '0) begin
                    state_d    = S_DONE;
                    freq_bcd_d = shifted[BW+CNT_W-1:CNT_W];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; sync stages reset high so a level held through reset
    // is not mistaken for an edge
    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            dly_q      <= 1'b1;
            gate_q     <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            freq_bin_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            sh_q       <= '0;
            acc_q      <= '0;
            step_q     <= '0;
            freq_bcd_q <= '0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            dly_q      <= dly_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            freq_bin_q <= freq_bin_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            freq_bcd_q <= freq_bcd_d;
        end
    end

    assign freq_bin = freq_bin_q;
    assign freq_bcd = freq_bcd_q;
    assign ovf      = ovf_q;
    assign busy     = (state_q == S_CONV);
    assign valid    = (state_q == S_DONE);

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (24-bit and 8-bit counters) share one
// stimulus; each gate window's sig_in pattern is generated as a whole block.
module tb_freq_meter;

    localparam int G  = 1000;
    localparam int CA = 24;
    localparam int DA = 8;
    localparam int CB = 8;
    localparam int DB = 3;

    localparam int M_SQ    = 0;
    localparam int M_LO    = 1;
    localparam int M_HI    = 2;
    localparam int M_LAST  = 3;
    localparam int M_FIRST = 4;
    localparam int M_RND   = 5;
    localparam int M_BOOT  = 6;

    logic clk_100M = 1'b0;
    logic rst      = 1'b1;
    logic sig_in   = 1'b1;

    logic [CA-1:0]   bin_a;
    logic [4*DA-1:0] bcd_a;
    logic            ovf_a, busy_a, valid_a;
    logic [CB-1:0]   bin_b;
    logic [4*DB-1:0] bcd_b;
    logic            ovf_b, busy_b, valid_b;

    always #5 clk_100M = ~clk_100M;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CA), .DIGITS(DA)) dut_a (
        .clk_100M(clk_100M), .rst(rst), .sig_in(sig_in),
        .freq_bin(bin_a), .freq_bcd(bcd_a), .ovf(ovf_a),
        .busy(busy_a), .valid(valid_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(CB), .DIGITS(DB)) dut_b (
        .clk_100M(clk_100M), .rst(rst), .sig_in(sig_in),
        .freq_bin(bin_b), .freq_bcd(bcd_b), .ovf(ovf_b),
        .busy(busy_b), .valid(valid_b)
    );

    typedef struct {
        int          mode;
        int          per;
        int          a_bin;
        logic [31:0] a_bcd;
        int          b_bin;
        logic [11:0] b_bcd;
        logic        b_ovf;
    } vec_t;

    vec_t tbl [15];

    bit lvl [G];
    bit last_lvl;

    int n_vec = 0;
    int n_err = 0;

    bit          have_prev;
    int          pa_bin, pb_bin;
    logic [31:0] pa_bcd;
    logic [11:0] pb_bcd;
    logic        pa_ovf, pb_ovf;

    int          e_a_bin, e_b_bin;
    logic [31:0] e_a_bcd;
    logic [11:0] e_b_bcd;
    logic        e_a_ovf, e_b_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Level seen by the DUT on each cycle of one gate window
    task automatic fill(input int mode, input int per, input int ph);
        bit p;
        p = last_lvl;
        for (int k = 0; k < G; k++) begin
            case (mode)
                M_SQ:    lvl[k] = ((k + ph) % per) >= (per / 2);
                M_LO:    lvl[k] = 1'b0;
                M_HI:    lvl[k] = 1'b1;
                M_LAST:  lvl[k] = (k == G - 1);
                M_FIRST: lvl[k] = (k == 0);
                M_RND:   lvl[k] = p ^ ($urandom_range(0, 99) < per);
                M_BOOT:  lvl[k] = (k < 5) ? 1'b1 : (((k + 10) % 20) < 10);
                default: lvl[k] = 1'b0;
            endcase
            p = lvl[k];
        end
    endtask

    // Reference: rising transitions of the sampled level in this window;
    // levels applied while in reset read as high
    function automatic int count_rises(input bit post_reset);
        int c;
        bit p, v;
        c = 0;
        p = post_reset ? 1'b1 : last_lvl;
        for (int k = 0; k < G; k++) begin
            v = (post_reset && k < 2) ? 1'b1 : lvl[k];
            if (v && !p) c++;
            p = v;
        end
        return c;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_expect(input bit post_reset);
        int c;
        logic [31:0] tmp;
        c = count_rises(post_reset);
        e_a_bin = (c > (1 << CA) - 1) ? (1 << CA) - 1 : c;
        e_a_ovf = (c > (1 << CA) - 1);
        e_b_bin = (c > (1 << CB) - 1) ? (1 << CB) - 1 : c;
        e_b_ovf = (c > (1 << CB) - 1);
        e_a_bcd = to_bcd(e_a_bin);
        tmp     = to_bcd(e_b_bin);
        e_b_bcd = tmp[11:0];
    endtask

    task automatic set_prev(input int ab, input logic [31:0] ad, input logic ao,
                            input int bb, input logic [11:0] bd, input logic bo);
        pa_bin = ab; pa_bcd = ad; pa_ovf = ao;
        pb_bin = bb; pb_bcd = bd; pb_ovf = bo;
        have_prev = 1'b1;
        last_lvl  = lvl[G-1];
    endtask

    // Drive one gate window of stimulus (block index k=2 is the cycle after
    // the previous window's gate end) and check the previous window's results
    task automatic run_block(input bit post_reset, input int abort_k);
        int va, vb;
        bit aborted;
        va = 0; vb = 0; aborted = 1'b0;
        for (int k = 0; k < G; k++) begin
            @(negedge clk_100M);
            if (post_reset && k < 2) begin
                chk("rst_out_a", {bin_a, bcd_a, ovf_a, busy_a, valid_a}, 64'd0);
                chk("rst_out_b", {bin_b, bcd_b, ovf_b, busy_b, valid_b}, 64'd0);
            end
            if (post_reset && k == 2) rst = 1'b0;
            va += int'(valid_a);
            vb += int'(valid_b);
            if (have_prev) begin
                if (k == 2) begin
                    chk("bin_a", bin_a, pa_bin);
                    chk("ovf_a", ovf_a, pa_ovf);
                    chk("busy_a", busy_a, 1);
                    chk("bin_b", bin_b, pb_bin);
                    chk("ovf_b", ovf_b, pb_ovf);
                    chk("busy_b", busy_b, 1);
                end
                if (k == CA + 2) begin
                    chk("valid_a", valid_a, 1);
                    chk("bcd_a", bcd_a, pa_bcd);
                    chk("busy_a_done", busy_a, 0);
                end
                if (k == CB + 2) begin
                    chk("valid_b", valid_b, 1);
                    chk("bcd_b", bcd_b, pb_bcd);
                    chk("busy_b_done", busy_b, 0);
                end
            end
            if (post_reset && k == G - 1) begin
                chk("hold_zero_a", {bin_a, bcd_a, ovf_a}, 64'd0);
                chk("hold_zero_b", {bin_b, bcd_b, ovf_b}, 64'd0);
            end
            if (k == abort_k) begin
                rst = 1'b1;
                aborted = 1'b1;
                #1;
                chk("abort_clear_a", {bin_a, bcd_a, ovf_a, busy_a, valid_a}, 64'd0);
                chk("abort_clear_b", {bin_b, bcd_b, ovf_b, busy_b, valid_b}, 64'd0);
                break;
            end
            sig_in = lvl[k];
        end
        if (!aborted) begin
            chk("valid_count_a", va, have_prev ? 1 : 0);
            chk("valid_count_b", vb, have_prev ? 1 : 0);
        end
    endtask

    initial begin
        tbl[0]  = '{M_SQ,    10, 100, 32'h100, 100, 12'h100, 1'b0};
        tbl[1]  = '{M_SQ,    20,  50, 32'h050,  50, 12'h050, 1'b0};
        tbl[2]  = '{M_SQ,     8, 125, 32'h125, 125, 12'h125, 1'b0};
        tbl[3]  = '{M_SQ,     2, 500, 32'h500, 255, 12'h255, 1'b1};
        tbl[4]  = '{M_SQ,    10, 100, 32'h100, 100, 12'h100, 1'b0};
        tbl[5]  = '{M_SQ,     4, 250, 32'h250, 250, 12'h250, 1'b0};
        tbl[6]  = '{M_LO,     0,   0, 32'h000,   0, 12'h000, 1'b0};
        tbl[7]  = '{M_HI,     0,   1, 32'h001,   1, 12'h001, 1'b0};
        tbl[8]  = '{M_HI,     0,   0, 32'h000,   0, 12'h000, 1'b0};
        tbl[9]  = '{M_LO,     0,   0, 32'h000,   0, 12'h000, 1'b0};
        tbl[10] = '{M_LAST,   0,   1, 32'h001,   1, 12'h001, 1'b0};
        tbl[11] = '{M_FIRST,  0,   0, 32'h000,   0, 12'h000, 1'b0};
        tbl[12] = '{M_FIRST,  0,   1, 32'h001,   1, 12'h001, 1'b0};
        tbl[13] = '{M_SQ,  1000,   1, 32'h001,   1, 12'h001, 1'b0};
        tbl[14] = '{M_SQ,    40,  25, 32'h025,  25, 12'h025, 1'b0};

        rst = 1'b1;
        sig_in = 1'b1;
        have_prev = 1'b0;
        last_lvl = 1'b1;
        repeat (3) @(negedge clk_100M);

        // sig_in high through reset and release, then period 20
        fill(M_BOOT, 0, 0);
        run_block(1'b1, -1);
        set_prev(50, 32'h50, 1'b0, 50, 12'h050, 1'b0);

        for (int i = 0; i < 15; i++) begin
            fill(tbl[i].mode, tbl[i].per, 0);
            run_block(1'b0, -1);
            set_prev(tbl[i].a_bin, tbl[i].a_bcd, 1'b0, tbl[i].b_bin, tbl[i].b_bcd, tbl[i].b_ovf);
        end

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 0)
                fill(M_SQ, int'($urandom_range(2, 64)), int'($urandom_range(0, 63)));
            else
                fill(M_RND, int'($urandom_range(5, 60)), 0);
            model_expect(1'b0);
            run_block(1'b0, -1);
            set_prev(e_a_bin, e_a_bcd, e_a_ovf, e_b_bin, e_b_bcd, e_b_ovf);
        end

        // Reset four cycles after the gate end, while conversion is running
        fill(M_SQ, 10, 0);
        run_block(1'b0, 6);
        have_prev = 1'b0;

        fill(M_RND, int'($urandom_range(10, 50)), 0);
        model_expect(1'b1);
        run_block(1'b1, -1);
        set_prev(e_a_bin, e_a_bcd, e_a_ovf, e_b_bin, e_b_bcd, e_b_ovf);

        fill(M_LO, 0, 0);
        run_block(1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
